// File: rtl/arith_pipe_alu.sv
// Two-stage signed ALU with valid/ready handshake, optional ADD/SUB saturation
// and a saturating count of overflow results taken by the downstream.
module arith_pipe_alu #(
    parameter int NB_DATA  = 16,
    parameter int NB_SEL   = 3,
    parameter int SATURATE = 1,
    parameter int NB_CNT   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [NB_DATA-1:0] i_data_a,
    input  logic signed [NB_DATA-1:0] i_data_b,
    input  logic        [NB_SEL-1:0]  i_sel,
    input  logic                      i_clear_cnt,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [NB_DATA-1:0] o_data_c,
    output logic                      o_zero,
    output logic                      o_neg,
    output logic                      o_ovf,
    output logic        [NB_CNT-1:0]  o_ovf_cnt
);

    localparam int MSB = NB_DATA - 1;
    localparam int SHW = $clog2(NB_DATA);
    localparam logic signed [NB_DATA-1:0] MAX_VAL = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic signed [NB_DATA-1:0] MIN_VAL = {1'b1, {(NB_DATA-1){1'b0}}};
    localparam logic signed [NB_DATA-1:0] ONE     = {{(NB_DATA-1){1'b0}}, 1'b1};

    logic                      s1_valid_q, s1_valid_d;
    logic signed [NB_DATA-1:0] a_q, a_d, b_q, b_d;
    logic        [NB_SEL-1:0]  sel_q, sel_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [NB_DATA-1:0] res_q, res_d;
    logic                      zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic        [NB_CNT-1:0]  cnt_q, cnt_d;

    logic                      en;
    logic signed [NB_DATA-1:0] sum, diff, alu_res;
    logic                      alu_ovf;

    assign en = ~out_valid_q | i_ready;

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = b_q;
        alu_ovf = 1'b0;
        case (sel_q)
            3'b000: begin
                alu_res = sum;
                alu_ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            3'b001: begin
                alu_res = diff;
                alu_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = (a_q < b_q) ? ONE : '0;
            3'b110:  alu_res = a_q >>> b_q[SHW-1:0];
            default: alu_res = b_q;
        endcase
        // An ADD/SUB overflow always has the true result's sign equal to a's sign.
        if ((SATURATE != 0) && alu_ovf) begin
            alu_res = a_q[MSB] ? MIN_VAL : MAX_VAL;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;

        if (en) begin
            s1_valid_d  = i_valid;
            out_valid_d = s1_valid_q;
            if (i_valid) begin
                a_d   = i_data_a;
                b_d   = i_data_b;
                sel_d = i_sel;
            end
            if (s1_valid_q) begin
                res_d  = alu_res;
                zero_d = (alu_res == '0);
                neg_d  = alu_res[MSB];
                ovf_d  = alu_ovf;
            end
        end

        if (i_clear_cnt) begin
            cnt_d = '0;
        end else if (out_valid_q && i_ready && ovf_q && !(&cnt_q)) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_ready   = en;
    assign o_valid   = out_valid_q;
    assign o_data_c  = res_q;
    assign o_zero    = zero_q;
    assign o_neg     = neg_q;
    assign o_ovf     = ovf_q;
    assign o_ovf_cnt = cnt_q;

endmodule

// File: doc/arith_pipe_alu.md
ARITH_PIPE_ALU -- requirements
Module: arith_pipe_alu

Parameters
REQ-001 The block SHALL have parameter NB_DATA, default 16, meaning operand and result width in bits (signed two's complement, minimum 4).
REQ-002 The block SHALL have parameter NB_SEL, default 3, meaning operation-select width (fixed at 3).
REQ-003 The block SHALL have parameter SATURATE, default 1, meaning 1 = ADD/SUB clamp on overflow and 0 = ADD/SUB wrap.
REQ-004 The block SHALL have parameter NB_CNT, default 8, meaning overflow-event counter width.

Interface
REQ-005 The block SHALL run on one clock and SHALL use an asynchronous, active-low reset.
REQ-006 The block SHALL have i_clk, input, 1 bit: rising-edge clock.
REQ-007 The block SHALL have i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have i_valid, input, 1 bit: operands and select present.
REQ-009 The block SHALL have o_ready, output, 1 bit: block accepts an input this cycle.
REQ-010 The block SHALL have i_data_a and i_data_b, input, NB_DATA bits, signed: operands.
REQ-011 The block SHALL have i_sel, input, NB_SEL bits: operation select.
REQ-012 The block SHALL have i_clear_cnt, input, 1 bit: synchronous clear of the overflow counter.
REQ-013 The block SHALL have o_valid, output, 1 bit: result present.
REQ-014 The block SHALL have i_ready, input, 1 bit: downstream accepts the result.
REQ-015 The block SHALL have o_data_c, output, NB_DATA bits, signed: result.
REQ-016 The block SHALL have o_zero, o_neg and o_ovf, output, 1 bit each: result flags.
REQ-017 The block SHALL have o_ovf_cnt, output, NB_CNT bits: count of accepted overflow results.

Function
REQ-018 The block SHALL decode i_sel as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SRA, 111 PASS_B.
  - SLT: result = 1 if a < b (signed), else 0.
  - SRA: arithmetic right shift of a by b[$clog2(NB_DATA)-1:0].
  - PASS_B: result = b.
REQ-019 The block SHALL compute ADD/SUB overflow as signed overflow (operand signs versus result sign); overflow SHALL be 0 for all other operations.
REQ-020 When SATURATE=1 and overflow occurs, o_data_c SHALL be the most positive value if the true result is positive, else the most negative value, and o_ovf SHALL still be 1.
REQ-021 When SATURATE=0, ADD/SUB results SHALL wrap modulo 2^NB_DATA.
REQ-022 o_zero SHALL equal (o_data_c == 0) and o_neg SHALL equal o_data_c[NB_DATA-1], both evaluated on the final (saturated) result.
REQ-023 The pipeline SHALL have two register stages:
  - stage 1 registers the operands and select;
  - stage 2 registers the result and flags.
REQ-024 Latency from an input handshake (i_valid & o_ready) to o_valid SHALL be exactly 2 cycles when there is no stall.
REQ-025 The pipeline SHALL advance when en = ~o_valid | i_ready, and o_ready SHALL equal en, combinationally.
REQ-026 When en = 0, both stages SHALL hold their contents, and o_data_c and the flags SHALL stay stable while o_valid = 1.
REQ-027 Stage valid bits SHALL propagate bubbles: an empty stage 1 SHALL produce o_valid = 0 on the next advance.
REQ-028 Full throughput SHALL be one result per cycle with i_valid and i_ready held at 1.
REQ-029 o_ovf_cnt SHALL increment by 1 on each output handshake (o_valid & i_ready) whose o_ovf = 1.
REQ-030 o_ovf_cnt SHALL saturate at all ones and SHALL not wrap.
REQ-031 When i_clear_cnt coincides with an overflow handshake, the counter SHALL take the value 0 (clear wins).
REQ-032 Data presented while o_ready = 0 SHALL NOT be captured.

Reset
REQ-033 Asserting i_rst_n = 0 SHALL asynchronously clear the following: both stage valid bits, o_valid, o_data_c, o_zero, o_neg, o_ovf and o_ovf_cnt; o_zero resets to 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight data.
REQ-035 After reset is released, o_ready SHALL be 1 on the first cycle and the first accepted input SHALL appear 2 cycles later.

Verification
REQ-036 Basic ops, NB_DATA=16, i_ready=1: ADD 100+(-30) -> 70 at cycle +2; SUB 5-5 -> 0 with o_zero=1; SLT -3,2 -> 1; SRA 0x8000 by 4 -> 0xF800 with o_neg=1.
REQ-037 Overflow, SATURATE=1: ADD 0x7FFF+1 -> 0x7FFF, o_ovf=1, o_ovf_cnt=1; SUB 0x8000-1 -> 0x8000, o_ovf=1, o_ovf_cnt=2.
REQ-038 Overflow, SATURATE=0: ADD 0x7FFF+1 -> 0x8000, o_ovf=1, o_neg=1.
REQ-039 Backpressure: stream 4 ADDs, drop i_ready low for 3 cycles after the first result -> o_ready=0 while full, output held stable, all 4 results delivered in order with none lost or duplicated.
REQ-040 Counter: NB_CNT=2 with 5 overflow results -> o_ovf_cnt sticks at 3; i_clear_cnt coinciding with an overflow handshake -> 0.
REQ-041 Reset: assert i_rst_n with 2 results in flight -> o_valid=0 and all outputs 0 immediately; no stale result appears after release.
